// File: rtl/array_store_unit.sv
// array_store_unit: conditional store of value to arr + (index % length) through an acked write port.
// Ports: clk, rst_n (async, active-low); req_* request handshake (arr, index, value,
// length, cond_sel); flags live condition inputs; mem_we/mem_waddr/mem_wdata with
// mem_wack; done_valid pulse with done_skipped/done_err qualifiers.
// Option: define ARRAY_STORE_FASTMOD_EN to bypass the divider when index < length.
module array_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FLAG_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_arr,
  input  logic [DATA_W-1:0]            req_index,
  input  logic [DATA_W-1:0]            req_value,
  input  logic [DATA_W-1:0]            req_length,
  input  logic [$clog2(FLAG_W+1)-1:0]  req_cond_sel,
  input  logic [FLAG_W-1:0]            flags,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_waddr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_wack,
  output logic                         done_valid,
  output logic                         done_skipped,
  output logic                         done_err
);
  localparam int SEL_W = $clog2(FLAG_W+1);
  localparam int EXT_W = 1 << SEL_W;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W-1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] arr_q, arr_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              skip_q, skip_d;
  logic              err_q, err_d;

  // Select values at or above FLAG_W land in the padding of ones: unconditional.
  logic [EXT_W-1:0]  flags_ext;
  logic              cond, len_zero, fast;
  logic [DATA_W-1:0] shifted;
  logic              sub_ge;

  assign flags_ext = {{(EXT_W-FLAG_W){1'b1}}, flags};
  assign cond      = flags_ext[req_cond_sel];
  assign len_zero  = req_length == '0;
`ifdef ARRAY_STORE_FASTMOD_EN
  assign fast      = req_index < req_length;
`else
  assign fast      = 1'b0;
`endif

  // Restoring step: a set remainder MSB means the shifted value exceeds any length,
  // and the wrapped DATA_W-bit difference is then still the exact remainder.
  assign shifted = {rem_q[DATA_W-2:0], idx_q[DATA_W-1]};
  assign sub_ge  = rem_q[DATA_W-1] | (shifted >= len_q);

  always_comb begin
    state_d = state_q;
    arr_d   = arr_q;
    val_d   = val_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        arr_d   = req_arr;
        val_d   = req_value;
        len_d   = req_length;
        idx_d   = req_index;
        rem_d   = fast ? req_index : '0;
        cnt_d   = '0;
        err_d   = len_zero;
        skip_d  = !len_zero && !cond;
        state_d = (len_zero || !cond) ? S_DONE : fast ? S_WRITE : S_DIV;
      end
      S_DIV: begin
        rem_d   = sub_ge ? shifted - len_q : shifted;
        idx_d   = {idx_q[DATA_W-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_LAST) ? S_WRITE : S_DIV;
      end
      S_WRITE: state_d = mem_wack ? S_DONE : S_WRITE;
      S_DONE:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      arr_q   <= '0;
      val_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arr_q   <= arr_d;
      val_q   <= val_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from state so reset drops a pending write at once.
  assign req_ready    = state_q == S_IDLE;
  assign mem_we       = state_q == S_WRITE;
  assign mem_waddr    = mem_we ? arr_q + ADDR_W'(rem_q) : '0;
  assign mem_wdata    = mem_we ? val_q : '0;
  assign done_valid   = state_q == S_DONE;
  assign done_skipped = done_valid & skip_q;
  assign done_err     = done_valid & err_q;
endmodule

// File: tb/tb_array_store_unit.sv
// tb_array_store_unit: randomized scoreboard bench for array_store_unit.
module tb_array_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_arr = '0, req_index = '0, req_value = '0, req_length = '0;
  logic [3:0]  req_cond_sel = '0;
  logic [7:0]  flags = '0;
  logic        mem_we;
  logic [31:0] mem_waddr, mem_wdata;
  logic        mem_wack = 1'b0;
  logic        done_valid, done_skipped, done_err;

`ifdef ARRAY_STORE_FASTMOD_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    bit          wr;
    bit          skip;
    bit          err;
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, ack_wait = 0;

  array_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_arr(req_arr), .req_index(req_index), .req_value(req_value),
    .req_length(req_length), .req_cond_sel(req_cond_sel), .flags(flags),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wack(mem_wack),
    .done_valid(done_valid), .done_skipped(done_skipped), .done_err(done_err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory side: ack after ack_wait withheld cycles; random noise on ack while not writing.
  initial begin
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        mem_wack = (w >= ack_wait);
        w++;
      end else begin
        mem_wack = 1'($urandom_range(0, 1));
        w = 0;
      end
    end
  end

  // Monitor: tracks the write of the current transaction and checks each completion.
  bit          seen;
  logic [31:0] wa, wd;
  exp_t        e;
  initial begin
    seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
        continue;
      end
      if (mem_we) begin
        if (!seen) begin
          seen = 1;
          wa = mem_waddr;
          wd = mem_wdata;
        end else begin
          chk("waddr_stable", mem_waddr, wa);
          chk("wdata_stable", mem_wdata, wd);
        end
      end
      if (done_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_skipped", done_skipped, e.skip);
          chk("done_err", done_err, e.err);
          chk("write_seen", seen, e.wr);
          if (e.wr) begin
            chk("waddr", wa, e.addr);
            chk("wdata", wd, e.data);
          end
          chk("done_cycle", cyc, e.due);
          chk("ready_low_in_done", req_ready, 0);
        end
        seen = 0;
      end
    end
  end

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Wait for idle; while busy, throw junk requests that must be ignored.
  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (req_ready) return;
      req_valid    = 1'($urandom_range(0, 1));
      req_index    = $urandom;
      req_length   = $urandom;
      req_arr      = $urandom;
      req_cond_sel = 4'($urandom_range(0, 15));
    end
    chk("idle_timeout", req_ready, 1);
    finish_run();
  endtask

  task automatic do_req(input logic [31:0] arr, input logic [31:0] idx, input logic [31:0] val,
                        input logic [31:0] len, input logic [3:0] sel, input logic [7:0] flg,
                        input int wt);
    exp_t x;
    bit cond;
    int lat;
    wait_idle();
    ack_wait     = wt;
    req_arr      = arr;
    req_index    = idx;
    req_value    = val;
    req_length   = len;
    req_cond_sel = sel;
    flags        = flg;
    req_valid    = 1'b1;
    cond   = (sel >= 8) || (((flg >> sel) & 8'd1) != 0);
    x.err  = (len == 0);
    x.skip = !x.err && !cond;
    x.wr   = !x.err && cond;
    x.addr = x.wr ? arr + (idx % len) : '0;
    x.data = val;
    lat    = x.wr ? ((FAST && idx < len) ? 1 : 33) + wt : 0;
    x.due  = cyc + 1 + lat;
    q.push_back(x);
    @(negedge clk);
    req_valid = 1'b0;
    flags     = 8'($urandom);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", {done_valid, done_skipped, done_err}, 0);
    rst_n = 1'b1;

    do_req(32'd100, 32'd7, 32'hDEAD, 32'd10, 4'd8, 8'h00, 0);
    do_req(32'd200, 32'd1234, 32'h1234_5678, 32'd100, 4'd15, 8'h00, 0);
    do_req(32'd50, 32'd9, 32'h0BAD, 32'd5, 4'd3, 8'h00, 0);
    do_req(32'd50, 32'd9, 32'h0600D, 32'd5, 4'd3, 8'h08, 0);
    do_req(32'd70, 32'd5, 32'h1111, 32'd0, 4'd3, 8'h00, 0);
    do_req(32'd70, 32'd5, 32'h2222, 32'd0, 4'd8, 8'hFF, 0);
    do_req(32'hFFFF_FFFE, 32'd5, 32'hCAFE, 32'd4, 4'd8, 8'h00, 3);
    do_req(32'hFFFF_FFFE, 32'd1, 32'hBEEF, 32'd4, 4'd7, 8'h80, 2);
    do_req(32'd0, 32'hFFFF_FFFF, 32'h5A5A, 32'hFFFF_FFFE, 4'd0, 8'h01, 1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] len, idx;
      int r;
      r = $urandom_range(0, 9);
      len = (r == 0) ? 32'd0 : (r < 5) ? 32'($urandom_range(1, 20)) :
            (r < 8) ? 32'($urandom_range(1, 1000)) : ($urandom | 32'd1);
      idx = $urandom_range(0, 1) ? 32'($urandom_range(0, 30)) : $urandom;
      do_req($urandom, idx, $urandom, len, 4'($urandom_range(0, 15)), 8'($urandom),
             $urandom_range(0, 3));
    end

    // Reset while dividing: request must vanish without a completion.
    do_req(32'd10, 32'd1234, 32'h7777, 32'd100, 4'd8, 8'h00, 0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_div_we", mem_we, 0);
    chk("rst_div_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset while a write is withheld: mem_we must drop asynchronously.
    do_req(32'd10, 32'd3, 32'h8888, 32'd5, 4'd8, 8'h00, 60);
    for (int i = 0; i < 100 && !mem_we; i++) @(negedge clk);
    chk("reached_write", mem_we, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_wr_we", mem_we, 0);
    chk("rst_wr_waddr", mem_waddr, 0);
    chk("rst_wr_ready", req_ready, 1);
    chk("rst_wr_done", done_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_req(32'd300, 32'd47, 32'h9999, 32'd8, 4'd8, 8'h00, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    finish_run();
  end
endmodule
